// File: rtl/demux_1x8.sv
// demux_1x8: registered 1-to-8 demux built from a 1x2 front stage feeding two 1x4 stages
module demux_1x4 (
    input  logic       en_i,
    input  logic [1:0] s_i,
    output logic [3:0] y_o
);
    always_comb y_o = en_i ? 4'b0001 << s_i : 4'b0000;
endmodule

module demux_1x8 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       din_i,
    input  logic [2:0] s_i,
    output logic [7:0] y_o
);
    logic       en_lo, en_hi;
    logic [7:0] y_d, y_q;
    always_comb begin
        en_lo = din_i & ~s_i[2];
        en_hi = din_i & s_i[2];
    end
    demux_1x4 u_lo (.en_i(en_lo), .s_i(s_i[1:0]), .y_o(y_d[3:0]));
    demux_1x4 u_hi (.en_i(en_hi), .s_i(s_i[1:0]), .y_o(y_d[7:4]));
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) y_q <= '0;
        else         y_q <= y_d;
    assign y_o = y_q;
endmodule

// File: tb/tb_demux_1x8.sv
// tb_demux_1x8: directed plus randomized checks of demux_1x8 against an indexed-bit reference
module tb_demux_1x8;
    logic       clk, rst_n, din;
    logic [2:0] s;
    logic [7:0] y;
    int         total = 0, bad = 0;

    demux_1x8 dut (.clk_i(clk), .rst_ni(rst_n), .din_i(din), .s_i(s), .y_o(y));

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_y(logic d, logic [2:0] sel);
        logic [7:0] r;
        r = '0;
        r[sel] = d;
        return r;
    endfunction

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(string tag, logic d, logic [2:0] sel);
        din = d;
        s = sel;
        @(posedge clk);
        #1;
        chk(tag, y, ref_y(d, sel));
        chk({tag, "_onehot"}, {7'b0, $countones(y) <= 1}, 8'h01);
    endtask

    initial begin
        rst_n = 1; din = 1; s = 3'b101;
        #2 rst_n = 0;
        #1 chk("rst_async", y, 8'h00);
        repeat (2) @(posedge clk);
        #1 chk("rst_held", y, 8'h00);
        rst_n = 1;
        @(posedge clk);
        #1 chk("rst_release", y, 8'h20);
        for (int i = 0; i < 8; i++) step("sweep1", 1'b1, 3'(i));
        for (int i = 0; i < 8; i++) step("sweep0", 1'b0, 3'(i));
        step("cross3", 1'b1, 3'd3);
        step("cross4", 1'b1, 3'd4);
        step("cross3b", 1'b1, 3'd3);
        step("mid_pre", 1'b1, 3'd6);
        chk("mid_y40", y, 8'h40);
        rst_n = 0;
        #1 chk("mid_async", y, 8'h00);
        #2 rst_n = 1;
        @(posedge clk);
        #1 chk("mid_release", y, 8'h40);
        step("lat_s0", 1'b1, 3'd0);
        s = 3'd7;
        #3 chk("lat_hold", y, 8'h01);
        @(posedge clk);
        #1 chk("lat_s7", y, 8'h80);
        for (int i = 0; i < 200; i++)
            step("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
